// File: rtl/game_pkg.sv
// Shared types and rank constants for the Higher-or-Lower card path.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int RANK_W = 4;
    localparam logic [RANK_W-1:0] RANK_MIN = 4'd1;
    localparam logic [RANK_W-1:0] RANK_MAX = 4'd13;

    // Deterministic substitute when sampling gives up: the rank after prev, wrapping 13 -> 1.
    function automatic logic [RANK_W-1:0] fallback_rank(input logic [RANK_W-1:0] prev);
        if ((prev == RANK_MAX) || (prev == 4'd0)) begin
            return RANK_MIN;
        end else begin
            return prev + 4'd1;
        end
    endfunction

endpackage

// File: rtl/rand_num_gen.sv
// Free-running right-shift Fibonacci LFSR; reseeds to 1 on reset.
module rand_num_gen #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [N-1:0] o_rand
);

    // x^8+x^6+x^5+x^4+1 for the 8-bit case; a short two-tap fallback otherwise.
    localparam logic [N-1:0] TAPS = (N == 8) ? N'(8'h1D) : N'(3);
    localparam logic [N-1:0] SEED = N'(1);

    logic [N-1:0] lfsr_q;
    logic [N-1:0] lfsr_d;

    // Next LFSR value: shift right, feedback parity enters at the MSB.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = {^(lfsr_q & TAPS), lfsr_q[N-1:1]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_rand = lfsr_q;

endmodule

// File: rtl/card_draw_ctrl.sv
// Deals ranks 1..13 by rejection-sampling an LFSR, with a bounded-retry fallback
// and a valid/ack handshake towards the game FSM.
module card_draw_ctrl
    import game_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_TRIES = 16,
    parameter int NO_REPEAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              draw_req,
    input  logic              card_ack,
    input  logic              clear,
    output logic [RANK_W-1:0] card,
    output logic              card_valid,
    output logic [RANK_W-1:0] prev_card,
    output logic              fallback,
    output logic              busy
);

    localparam int RW = $clog2(MAX_TRIES + 1);
    localparam logic [RW-1:0] LAST_TRY = RW'(MAX_TRIES - 1);

    logic [N-1:0]      rand_s;
    logic              rng_reset_s;
    logic [RANK_W-1:0] cand_s;
    logic              accept_s;
    logic              last_try_s;
    logic              unused_rand_s;

    state_e            state_q, state_d;
    logic [RANK_W-1:0] card_q, card_d;
    logic [RANK_W-1:0] prev_q, prev_d;
    logic              valid_q, valid_d;
    logic              fb_q, fb_d;
    logic              busy_q, busy_d;
    logic [RW-1:0]     retry_q, retry_d;

    assign rng_reset_s = ~reset_n;

    rand_num_gen #(.N(N)) u_rng (
        .clk    (clk),
        .reset  (rng_reset_s),
        .enable (1'b1),
        .o_rand (rand_s)
    );

    assign cand_s        = rand_s[RANK_W-1:0];
    assign unused_rand_s = ^rand_s[N-1:RANK_W];
    assign accept_s      = (cand_s >= RANK_MIN) && (cand_s <= RANK_MAX) &&
                           ((NO_REPEAT == 0) || (cand_s != prev_q));
    assign last_try_s    = (retry_q == LAST_TRY);

    // Next-state and output decode for the IDLE/DRAW/HOLD sequencer.
    always_comb begin
        state_d = state_q;
        card_d  = card_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        fb_d    = fb_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    prev_d = 4'd0;
                end else begin
                    prev_d = prev_q;
                end
                if (draw_req) begin
                    state_d = DRAW;
                    retry_d = {RW{1'b0}};
                    fb_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAW: begin
                if (accept_s) begin
                    card_d  = cand_s;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (last_try_s) begin
                    card_d  = fallback_rank(prev_q);
                    fb_d    = 1'b1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    retry_d = retry_q + RW'(1);
                end
            end
            HOLD: begin
                if (card_ack) begin
                    prev_d  = card_q;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            card_q  <= 4'd0;
            prev_q  <= 4'd0;
            valid_q <= 1'b0;
            fb_q    <= 1'b0;
            busy_q  <= 1'b0;
            retry_q <= {RW{1'b0}};
        end else begin
            state_q <= state_d;
            card_q  <= card_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            fb_q    <= fb_d;
            busy_q  <= busy_d;
            retry_q <= retry_d;
        end
    end

    assign card       = card_q;
    assign card_valid = valid_q;
    assign prev_card  = prev_q;
    assign fallback   = fb_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_card_draw_ctrl.sv
// Bench for card_draw_ctrl: default instance (A) and a MAX_TRIES=4 instance (B),
// checked against a draw-level model built on the LFSR value history.
module tb_card_draw_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [1:0]      draw_req, card_ack, clear;
    logic [1:0][3:0] card, prev_card;
    logic [1:0]      card_valid, fallback, busy;

    card_draw_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .draw_req(draw_req[0]), .card_ack(card_ack[0]),
        .clear(clear[0]), .card(card[0]), .card_valid(card_valid[0]),
        .prev_card(prev_card[0]), .fallback(fallback[0]), .busy(busy[0])
    );

    card_draw_ctrl #(.MAX_TRIES(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .draw_req(draw_req[1]), .card_ack(card_ack[1]),
        .clear(clear[1]), .card(card[1]), .card_valid(card_valid[1]),
        .prev_card(prev_card[1]), .fallback(fallback[1]), .busy(busy[1])
    );

    localparam int SEQ_LEN = 4096;

    int         n_cmp = 0;
    int         n_err = 0;
    int         edge_cnt;
    logic [7:0] seq [SEQ_LEN];
    int         prev_m [2];
    int         maxt [2];

    // Edges since reset release: seq[edge_cnt] is the LFSR value now.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // A draw started on edge e scans the values seen by the following edges.
    task automatic predict(input int e, input int prev, input int mx,
                           output int c, output int fb, output int lat);
        c = (prev == 13 || prev == 0) ? 1 : prev + 1;
        fb = 1;
        lat = mx;
        for (int j = 0; j < mx; j++) begin
            int r;
            r = (e + j < SEQ_LEN) ? int'(seq[e + j] % 16) : 0;
            if (r >= 1 && r <= 13 && r != prev) begin
                c = r; fb = 0; lat = j + 1;
                break;
            end
        end
    endtask

    task automatic do_draw(input int id, input bit clr, input int gap, output int got);
        int e, c, fb, lat, n;
        for (int g = 0; g < gap; g++) begin
            card_ack[id] = 1'($urandom % 2);
            tick;
        end
        card_ack[id] = 1'b0;
        draw_req[id] = 1'b1;
        clear[id] = clr;
        tick;
        e = edge_cnt;
        draw_req[id] = 1'b0;
        clear[id] = 1'b0;
        if (clr) prev_m[id] = 0;
        n_cmp++; if (busy[id] !== 1'b1 || card_valid[id] !== 1'b0) begin n_err++;
            $display("FAIL draw_start[%0d]: busy=%0b valid=%0b want 1/0", id, busy[id], card_valid[id]); end
        n_cmp++; if (int'(prev_card[id]) != prev_m[id]) begin n_err++;
            $display("FAIL draw_prev[%0d]: got %0d want %0d", id, prev_card[id], prev_m[id]); end
        predict(e, prev_m[id], maxt[id], c, fb, lat);
        n = 0;
        while (card_valid[id] !== 1'b1 && n < maxt[id] + 2) begin
            draw_req[id] = 1'($urandom % 2);
            clear[id] = 1'($urandom % 2);
            tick;
            n++;
        end
        draw_req[id] = 1'b0;
        clear[id] = 1'b0;
        n_cmp++; if (card_valid[id] !== 1'b1 || edge_cnt != e + lat) begin n_err++;
            $display("FAIL draw_latency[%0d]: valid=%0b at edge %0d want edge %0d", id, card_valid[id], edge_cnt, e + lat); end
        n_cmp++; if (int'(card[id]) != c || int'(fallback[id]) != fb) begin n_err++;
            $display("FAIL draw_card[%0d]: card=%0d fb=%0b want %0d/%0d", id, card[id], fallback[id], c, fb); end
        repeat ($urandom_range(0, 4)) begin
            draw_req[id] = 1'($urandom % 2);
            clear[id] = 1'($urandom % 2);
            tick;
            n_cmp++; if (int'(card[id]) != c || card_valid[id] !== 1'b1) begin n_err++;
                $display("FAIL draw_hold[%0d]: card=%0d valid=%0b want %0d/1", id, card[id], card_valid[id], c); end
        end
        draw_req[id] = 1'b0;
        clear[id] = 1'b0;
        card_ack[id] = 1'b1;
        tick;
        card_ack[id] = 1'b0;
        n_cmp++; if (card_valid[id] !== 1'b0 || int'(prev_card[id]) != c || busy[id] !== 1'b0) begin n_err++;
            $display("FAIL draw_ack[%0d]: valid=%0b prev=%0d busy=%0b want 0/%0d/0", id, card_valid[id], prev_card[id], busy[id], c); end
        prev_m[id] = c;
        got = c;
    endtask

    task automatic check_zero(input string tag);
        for (int id = 0; id < 2; id++) begin
            n_cmp++; if (card[id] !== 4'd0 || prev_card[id] !== 4'd0) begin n_err++;
                $display("FAIL %s_ranks[%0d]: card=%0d prev=%0d want 0/0", tag, id, card[id], prev_card[id]); end
            n_cmp++; if (card_valid[id] !== 1'b0 || fallback[id] !== 1'b0 || busy[id] !== 1'b0) begin n_err++;
                $display("FAIL %s_flags[%0d]: valid=%0b fb=%0b busy=%0b want 0", tag, id, card_valid[id], fallback[id], busy[id]); end
        end
        n_cmp++; if (dut_a.u_rng.o_rand !== 8'h01) begin n_err++;
            $display("FAIL %s_lfsr: got %02h want 01", tag, dut_a.u_rng.o_rand); end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        prev_m[0] = 0;
        prev_m[1] = 0;
    endtask

    // Both instances get draw_req before edge 1; B runs out of tries on edge 5.
    task automatic test_first_draw;
        draw_req = 2'b11;
        tick;
        draw_req = 2'b00;
        for (int k = 2; k <= 6; k++) begin
            tick;
            if (k <= 5) begin
                n_cmp++; if (card_valid[0] !== 1'b0 || busy[0] !== 1'b1) begin n_err++;
                    $display("FAIL first_reject edge %0d: valid=%0b busy=%0b want 0/1", k, card_valid[0], busy[0]); end
            end else begin
                n_cmp++; if (card[0] !== 4'd8 || card_valid[0] !== 1'b1 || fallback[0] !== 1'b0 || busy[0] !== 1'b1) begin n_err++;
                    $display("FAIL first_accept: card=%0d valid=%0b fb=%0b busy=%0b want 8/1/0/1", card[0], card_valid[0], fallback[0], busy[0]); end
            end
            if (k < 5) begin
                n_cmp++; if (card_valid[1] !== 1'b0) begin n_err++;
                    $display("FAIL fb_early edge %0d: valid=%0b want 0", k, card_valid[1]); end
            end else if (k == 5) begin
                n_cmp++; if (card[1] !== 4'd1 || fallback[1] !== 1'b1 || card_valid[1] !== 1'b1) begin n_err++;
                    $display("FAIL fb_card: card=%0d fb=%0b valid=%0b want 1/1/1", card[1], fallback[1], card_valid[1]); end
            end
        end
    endtask

    task automatic test_ack_repeat;
        card_ack[0] = 1'b1;
        tick;
        card_ack[0] = 1'b0;
        n_cmp++; if (prev_card[0] !== 4'd8 || card_valid[0] !== 1'b0 || card[0] !== 4'd8 || busy[0] !== 1'b0) begin n_err++;
            $display("FAIL ack: prev=%0d valid=%0b card=%0d busy=%0b want 8/0/8/0", prev_card[0], card_valid[0], card[0], busy[0]); end
        tick;
        draw_req[0] = 1'b1;
        tick;
        draw_req[0] = 1'b0;
        n_cmp++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL redraw_busy: got %0b want 1", busy[0]); end
        tick;
        n_cmp++; if (card_valid[0] !== 1'b0) begin n_err++;
            $display("FAIL repeat_reject: valid=%0b card=%0d want valid 0", card_valid[0], card[0]); end
        tick;
        n_cmp++; if (card[0] !== 4'd12 || card_valid[0] !== 1'b1 || fallback[0] !== 1'b0) begin n_err++;
            $display("FAIL second_card: card=%0d valid=%0b fb=%0b want 12/1/0", card[0], card_valid[0], fallback[0]); end
        prev_m[0] = 8;
    endtask

    task automatic test_hold;
        for (int i = 0; i < 20; i++) begin
            draw_req = 2'($urandom);
            tick;
            n_cmp++; if (card[0] !== 4'd12 || card_valid[0] !== 1'b1 || busy[0] !== 1'b1 ||
                         card[1] !== 4'd1 || card_valid[1] !== 1'b1) begin n_err++;
                $display("FAIL hold cycle %0d: A=%0d/%0b B=%0d/%0b want 12/1 1/1", i, card[0], card_valid[0], card[1], card_valid[1]); end
        end
        draw_req = 2'b00;
        card_ack = 2'b11;
        tick;
        card_ack = 2'b00;
        n_cmp++; if (prev_card[0] !== 4'd12 || prev_card[1] !== 4'd1 || busy !== 2'b00) begin n_err++;
            $display("FAIL hold_ack: prevA=%0d prevB=%0d busy=%b want 12/1/00", prev_card[0], prev_card[1], busy); end
        prev_m[0] = 12;
        prev_m[1] = 1;
    endtask

    task automatic test_reset_mid_draw;
        draw_req[0] = 1'b1;
        tick;
        draw_req[0] = 1'b0;
        reset_n = 1'b0;
        #2;
        check_zero("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        prev_m[0] = 0;
        prev_m[1] = 0;
        test_first_draw;
        card_ack = 2'b11;
        tick;
        card_ack = 2'b00;
        n_cmp++; if (prev_card[0] !== 4'd8 || prev_card[1] !== 4'd1) begin n_err++;
            $display("FAIL replay_ack: prevA=%0d prevB=%0d want 8/1", prev_card[0], prev_card[1]); end
        prev_m[0] = 8;
        prev_m[1] = 1;
    endtask

    task automatic test_clear;
        int found, c, fb, lat, got;
        clear[0] = 1'b1;
        tick;
        clear[0] = 1'b0;
        n_cmp++; if (prev_card[0] !== 4'd0 || busy[0] !== 1'b0) begin n_err++;
            $display("FAIL clear: prev=%0d busy=%0b want 0/0", prev_card[0], busy[0]); end
        prev_m[0] = 0;
        found = -1;
        for (int d = 1; d <= 300; d++) begin
            predict(edge_cnt + d, 0, maxt[0], c, fb, lat);
            if (c == 8 && fb == 0) begin found = d; break; end
        end
        n_cmp++; if (found < 0) begin n_err++;
            $display("FAIL clear_search: got no start edge want one dealing 8"); end
        else begin
            do_draw(0, 1'b0, found - 1, got);
            n_cmp++; if (got != 8) begin n_err++;
                $display("FAIL clear_redeal: got %0d want 8", got); end
        end
    endtask

    task automatic test_random(input int id, input int count);
        int got;
        for (int i = 0; i < count; i++) begin
            do_draw(id, 1'(($urandom % 4) == 0), $urandom_range(0, 6), got);
        end
    endtask

    initial begin
        maxt[0] = 16;
        maxt[1] = 4;
        // LFSR history for x^8+x^6+x^5+x^4+1, right-shifting, seeded with 1.
        seq[0] = 8'h01;
        for (int k = 1; k < SEQ_LEN; k++) begin
            seq[k] = {seq[k-1][0] ^ seq[k-1][2] ^ seq[k-1][3] ^ seq[k-1][4], seq[k-1][7:1]};
        end
        reset_n  = 1'b0;
        draw_req = 2'b00;
        card_ack = 2'b00;
        clear    = 2'b00;
        test_reset;
        test_first_draw;
        test_ack_repeat;
        test_hold;
        test_reset_mid_draw;
        test_clear;
        test_random(0, 30);
        test_random(1, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
